// File: rtl/bp_pkg.sv
// Shared constants and saturating-counter helpers for the gshare/bimodal branch predictor.
package bp_pkg;

  localparam int DEF_PC_W   = 8;
  localparam int DEF_IDX_W  = 6;
  localparam int DEF_CTR_W  = 2;
  localparam int DEF_GHR_W  = 6;
  localparam int DEF_STAT_W = 16;

  // Helpers work on the widest legal counter; callers truncate to CTR_W.
  localparam int MAX_CTR_W = 4;
  typedef logic [MAX_CTR_W-1:0] ctrWide_t;

  function automatic ctrWide_t ctrReset(input int ctrW);
    return ctrWide_t'((1 << (ctrW - 1)) - 1);
  endfunction

  function automatic ctrWide_t ctrMax(input int ctrW);
    return ctrWide_t'((1 << ctrW) - 1);
  endfunction

  function automatic ctrWide_t satInc(input ctrWide_t val, input int ctrW);
    return (val == ctrMax(ctrW)) ? val : val + ctrWide_t'(1);
  endfunction

  function automatic ctrWide_t satDec(input ctrWide_t val);
    return (val == '0) ? val : val - ctrWide_t'(1);
  endfunction

  function automatic ctrWide_t satUpdate(input ctrWide_t val, input logic up, input int ctrW);
    return up ? satInc(val, ctrW) : satDec(val);
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Saturating-counter pattern table: one combinational lookup port and one
// read-modify-write update port; a same-cycle lookup sees the pre-update value.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int CTR_W = DEF_CTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rdIdx,
  output logic [CTR_W-1:0] o_rdCtr,
  input  logic             i_updEn,
  input  logic [IDX_W-1:0] i_updIdx,
  input  logic             i_updTaken
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_RESET = CTR_W'(ctrReset(CTR_W));

  logic [CTR_W-1:0] r_ctr [DEPTH];
  logic [CTR_W-1:0] w_updNext;

  assign o_rdCtr   = r_ctr[i_rdIdx];
  assign w_updNext = CTR_W'(satUpdate(ctrWide_t'(r_ctr[i_updIdx]), i_updTaken, CTR_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= CTR_RESET;
      end
    end else if (i_updEn) begin
      r_ctr[i_updIdx] <= w_updNext;
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Fetch-side direction predictor with EX-stage resolution and statistics.
// Define GSHARE_BP_GSHARE_EN for gshare indexing with a speculative GHR; otherwise bimodal.
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int CTR_W  = DEF_CTR_W,
  parameter int GHR_W  = DEF_GHR_W,
  parameter int STAT_W = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              f_valid,
  input  logic              f_is_branch,
  input  logic [PC_W-1:0]   f_pc,
  input  logic [PC_W-1:0]   f_pc_plus1,
  input  logic [PC_W-1:0]   f_target,
  output logic              p_taken,
  output logic [PC_W-1:0]   p_next_pc,
  output logic [IDX_W-1:0]  p_idx,
  output logic [GHR_W-1:0]  p_ghr,
  input  logic              r_valid,
  input  logic              r_taken,
  input  logic              r_pred_taken,
  input  logic [IDX_W-1:0]  r_idx,
  input  logic [GHR_W-1:0]  r_ghr,
  input  logic [PC_W-1:0]   r_target,
  input  logic [PC_W-1:0]   r_pc_plus1,
  output logic              mispredict,
  output logic [PC_W-1:0]   corrected_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  logic              w_fetchBranch;
  logic [IDX_W-1:0]  w_idx;
  logic [CTR_W-1:0]  w_ctr;
  logic [GHR_W-1:0]  w_ghr;
  logic              w_unused;
  logic [STAT_W-1:0] r_statBranches;
  logic [STAT_W-1:0] r_statMispredicts;

  assign w_fetchBranch = f_valid && f_is_branch;
  assign w_unused      = ^{f_pc, r_ghr, stall};

`ifdef GSHARE_BP_GSHARE_EN
  logic [GHR_W-1:0] r_ghrSpec;

  // Recovery from a mispredict wins over the speculative shift of a fetched branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghrSpec <= '0;
    end else if (mispredict) begin
      r_ghrSpec <= {r_ghr[GHR_W-2:0], r_taken};
    end else if (w_fetchBranch && !stall) begin
      r_ghrSpec <= {r_ghrSpec[GHR_W-2:0], p_taken};
    end
  end

  assign w_ghr = r_ghrSpec;
  assign w_idx = f_pc[IDX_W-1:0] ^ IDX_W'(r_ghrSpec);
`else
  assign w_ghr = '0;
  assign w_idx = f_pc[IDX_W-1:0];
`endif

  bp_counter_table #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .i_rdIdx    (w_idx),
    .o_rdCtr    (w_ctr),
    .i_updEn    (r_valid),
    .i_updIdx   (r_idx),
    .i_updTaken (r_taken)
  );

  assign p_taken      = w_fetchBranch && w_ctr[CTR_W-1];
  assign p_next_pc    = p_taken ? f_target : f_pc_plus1;
  assign p_idx        = w_idx;
  assign p_ghr        = w_ghr;
  assign mispredict   = r_valid && (r_taken != r_pred_taken);
  assign corrected_pc = r_taken ? r_target : r_pc_plus1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_statBranches    <= '0;
      r_statMispredicts <= '0;
    end else if (r_valid) begin
      if (~&r_statBranches) begin
        r_statBranches <= r_statBranches + STAT_W'(1);
      end
      if (mispredict && ~&r_statMispredicts) begin
        r_statMispredicts <= r_statMispredicts + STAT_W'(1);
      end
    end
  end

  assign stat_branches    = r_statBranches;
  assign stat_mispredicts = r_statMispredicts;

endmodule

// File: doc/gshare_branch_predictor.md
# gshare_branch_predictor

Parametrised dynamic branch predictor for the pipelined core, replacing the fixed single-entry predict/correct logic. It sits beside fetch: it predicts the next PC in the fetch cycle, carries the table index and history checkpoint down the pipe with the branch, and accepts resolution from EX. It also provides:
- a table of saturating counters (configurable depth and width);
- a speculative global history register with checkpoint recovery;
- saturating branch and mispredict statistics counters.

## Interface
Parameters:
- PC_W, 8, PC and target width.
- IDX_W, 6, log2 of table depth (depth = 2**IDX_W).
- CTR_W, 2, counter width, 2..4.
- GHR_W, 6, history length; must be ≤ IDX_W.
- STAT_W, 16, statistics counter width.

Ports:
- clk in 1: single clock; all state updates on rising edge.
- rst in 1: reset, synchronous, active-high.
- stall in 1: fetch held; suppresses the speculative history update.
- f_valid in 1: fetch slot holds a real instruction.
- f_is_branch in 1: predecoded conditional branch in the fetch slot.
- f_pc in PC_W: PC of the fetched instruction.
- f_pc_plus1 in PC_W: sequential PC.
- f_target in PC_W: branch target from the fetch-stage adder.
- p_taken out 1: predicted direction; 0 unless f_valid && f_is_branch.
- p_next_pc out PC_W: p_taken ? f_target : f_pc_plus1.
- p_idx out IDX_W: table index used; piped to EX with the branch.
- p_ghr out GHR_W: history before this prediction (checkpoint); piped to EX.
- r_valid in 1: a branch resolved in EX this cycle.
- r_taken in 1: actual direction.
- r_pred_taken in 1: direction predicted for it.
- r_idx in IDX_W: its p_idx.
- r_ghr in GHR_W: its p_ghr.
- r_target in PC_W: its branch target.
- r_pc_plus1 in PC_W: its sequential PC.
- mispredict out 1: r_valid && (r_taken != r_pred_taken).
- corrected_pc out PC_W: r_taken ? r_target : r_pc_plus1; meaningful only when mispredict.
- stat_branches out STAT_W: resolved branch count.
- stat_mispredicts out STAT_W: mispredict count.

## Operation
- Lookup is combinational from the registered table in the fetch cycle: p_taken = MSB of counter[idx].
- Index: idx = f_pc[IDX_W-1:0] XOR zero-extended ghr (see Configuration).
- Counter update on r_valid: at the edge, counter[r_idx] saturating increments if r_taken, else decrements.
  - Saturation bounds: 0 and 2**CTR_W-1; no wrap.
- Speculative history: on an edge with f_valid && f_is_branch && !stall && !mispredict, ghr <= {ghr[GHR_W-2:0], p_taken}.
- Recovery: on an edge with mispredict, ghr <= {r_ghr[GHR_W-2:0], r_taken}. Recovery overrides any fetch update in the same cycle.
- Correctly predicted resolutions leave ghr untouched.
- Statistics, on r_valid:
  - stat_branches increments.
  - stat_mispredicts increments when mispredict.
  - Both saturate at all-ones.
- Outputs mispredict and corrected_pc are combinational from the r_* inputs. The hazard unit uses them to flush IF/ID and ID/EX and to redirect the PC.

## Timing
- Prediction latency 0: p_* valid in the same cycle as f_*.
- Table update visible to a lookup of the same index starting the cycle after r_valid. A same-cycle lookup of that index sees the old value; there is no bypass.
- Mispredict and redirect occur in the resolve cycle. The restored ghr is used from the next cycle.
- Reset values, applied on the first edge with rst=1:
  - every counter = 2**(CTR_W-1)-1 (weakly not-taken);
  - ghr = 0;
  - both statistics counters = 0.
- Combinational outputs under reset follow the reset-state table and ghr.
- r_valid and fetch inputs are ignored on edges where rst=1. A reset during a pending resolution discards it.
- stall freezes only the ghr speculative update; resolution, table update and statistics proceed during stall.

## Configuration
- GSHARE_BP_GSHARE_EN defined:
  - idx = f_pc[IDX_W-1:0] ^ ghr, with ghr zero-extended to IDX_W.
  - GHR, recovery logic and p_ghr are active.
- GSHARE_BP_GSHARE_EN not defined: bimodal predictor.
  - idx = f_pc[IDX_W-1:0].
  - No GHR register; p_ghr tied to 0; r_ghr ignored.
  - All other behaviour identical.

## Structure
- Shared package bp_pkg holds:
  - the counter reset constant and saturating inc/dec functions, parametrised by CTR_W;
  - the default parameter constants.
- Sub-module bp_counter_table holds the counter array:
  - one combinational read port;
  - one synchronous read-modify-write update port;
  - synchronous reset.
- The top level holds the index hash, GHR, statistics and the correction logic.

## Test plan
- Reset then lookup f_pc=8'h10 with f_is_branch=1 -> p_taken=0, p_next_pc=f_pc_plus1=8'h11, p_ghr=0.
- Two resolutions at idx 5 with r_taken=1 -> counter[5] 01→10→11; a lookup hitting idx 5 gives p_taken=1, p_next_pc=f_target. Four more with r_taken=1 -> counter stays 11.
- r_valid=1, r_pred_taken=0, r_taken=1, r_target=8'h40 -> mispredict=1, corrected_pc=8'h40. With GSHARE_EN and r_ghr=6'b000101, next-cycle ghr=6'b001011.
- Same-cycle mispredict and fetch branch, without stall -> ghr takes the recovered value; the fetch shift is dropped.
- stall=1 with three fetch branches -> ghr unchanged; a concurrent r_valid still updates its counter and stat_branches.
- Preload stat counters near all-ones (STAT_W=4 build) and send 20 mispredicts -> both counters hold at 4'hF. Assert rst mid-stream -> all counters, ghr and stats return to reset values on the next edge.
